seg7_reader: RTL

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// Seven-segment display reader: debounces active-low segment patterns, decodes them
// to hex digits, and hands results to a consumer over a valid/ready handshake.
module seg7_reader #(
  parameter int STABLE_CNT = 3,
  parameter int DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic                  sample_en,
  input  logic                  out_ready,
  input  logic                  clr_ovr,
  output logic                  out_valid,
  output logic [3:0]            out_digit,
  output logic                  out_err,
  output logic [4*DIGITS-1:0]   digits_q,
  output logic                  overrun
);

  localparam logic [6:0] BLANK   = 7'b1111111;
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    EMIT    = 2'd2,
    SETTLED = 2'd3
  } state_t;

  // Returns {err, digit}; unknown patterns decode to err=1, digit=0.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0000001: res = 5'h00;
      7'b1001111: res = 5'h01;
      7'b0010010: res = 5'h02;
      7'b0000110: res = 5'h03;
      7'b1001100: res = 5'h04;
      7'b0100100: res = 5'h05;
      7'b0100000: res = 5'h06;
      7'b0001111: res = 5'h07;
      7'b0000000: res = 5'h08;
      7'b0000100: res = 5'h09;
      7'b0001000: res = 5'h0A;
      7'b1100000: res = 5'h0B;
      7'b0110001: res = 5'h0C;
      7'b1000010: res = 5'h0D;
      7'b0110000: res = 5'h0E;
      7'b0111000: res = 5'h0F;
      default:    res = 5'h10;
    endcase
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [6:0]          cand_q, cand_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [6:0]          last_rep_q, last_rep_d;
  logic                valid_q, valid_d;
  logic [3:0]          digit_q, digit_d;
  logic                err_q, err_d;
  logic [4*DIGITS-1:0] hist_q, hist_d;
  logic                ovr_q, ovr_d;

  logic                same_s, qual_s, issue_s, accept_s, drop_s, load_s;
  logic [3:0]          cnt_nx_s;
  logic [4:0]          dec_s;

  // Qualification and handshake event decode for the current cycle.
  always_comb begin
    same_s = (seg_in == cand_q);
    if (!same_s) begin
      cnt_nx_s = 4'd1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_nx_s = CNT_MAX;
    end else begin
      cnt_nx_s = cnt_q + 4'd1;
    end
    // A saturated count that stays saturated is not a new qualification.
    qual_s   = sample_en && (cnt_nx_s == CNT_MAX) && !(same_s && (cnt_q == CNT_MAX));
    issue_s  = qual_s && (seg_in != BLANK) && (seg_in != last_rep_q);
    accept_s = valid_q && out_ready;
    drop_s   = issue_s && valid_q && !out_ready;
    load_s   = issue_s && !drop_s;
    dec_s    = decode_seg(seg_in);
  end

  // Next-state computation for candidate tracking, result slot, history and overrun.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    last_rep_d = last_rep_q;
    valid_d    = valid_q;
    digit_d    = digit_q;
    err_d      = err_q;
    hist_d     = hist_q;
    ovr_d      = ovr_q;
    state_d    = state_q;

    if (sample_en) begin
      cand_d = seg_in;
      cnt_d  = cnt_nx_s;
    end else begin
      cnt_d  = cnt_q;
    end

    if (qual_s && (seg_in == BLANK)) begin
      last_rep_d = BLANK;
    end else if (load_s) begin
      last_rep_d = seg_in;
    end else begin
      last_rep_d = last_rep_q;
    end

    if (accept_s && !err_q) begin
      hist_d = {hist_q[4*DIGITS-5:0], digit_q};
    end else begin
      hist_d = hist_q;
    end

    if (load_s) begin
      valid_d = 1'b1;
      digit_d = dec_s[3:0];
      err_d   = dec_s[4];
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (valid_d) begin
      state_d = EMIT;
    end else if (qual_s) begin
      state_d = SETTLED;
    end else begin
      case (state_q)
        IDLE:    state_d = sample_en ? QUAL : IDLE;
        QUAL:    state_d = QUAL;
        EMIT:    state_d = (sample_en && !same_s) ? QUAL : SETTLED;
        SETTLED: state_d = (sample_en && !same_s) ? QUAL : SETTLED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Single state/output register bank with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cand_q     <= BLANK;
      cnt_q      <= 4'd0;
      last_rep_q <= BLANK;
      valid_q    <= 1'b0;
      digit_q    <= 4'd0;
      err_q      <= 1'b0;
      hist_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      last_rep_q <= last_rep_d;
      valid_q    <= valid_d;
      digit_q    <= digit_d;
      err_q      <= err_d;
      hist_q     <= hist_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_digit = digit_q;
  assign out_err   = err_q;
  assign digits_q  = hist_q;
  assign overrun   = ovr_q;

endmodule
